// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store encodings plus the LSU sequencer state type.
// Also holds the funct3 legality check used at the request handshake.
package riscv_pkg;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_RESP = 2'd3
   } lsu_state_t;

   // Unsigned variants only make sense for loads.
   function automatic logic funct3_legal(input logic [2:0] funct3, input logic we);
      logic ok;
      case (funct3)
         FUNCT3_B, FUNCT3_H, FUNCT3_W: ok = 1'b1;
         FUNCT3_BU, FUNCT3_HU:         ok = ~we;
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store lane steering: byte enables, replicated write data
// and alignment check for an access size and byte offset.
module lsu_store_align
   import riscv_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic        misaligned
);

   // Decode size (funct3[1:0]) into lanes; unknown size yields no lanes.
   always_comb begin
      be         = 4'b0000;
      wdata_rep  = 32'h0000_0000;
      misaligned = 1'b0;
      case (size)
         2'b00: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{wdata[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << {off[1], 1'b0};
            wdata_rep  = {2{wdata[15:0]}};
            misaligned = off[0];
         end
         2'b10: begin
            be         = 4'b1111;
            wdata_rep  = wdata;
            misaligned = (off != 2'b00);
         end
         default: begin
            be         = 4'b0000;
            wdata_rep  = 32'h0000_0000;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a req/gnt/rvalid memory port.
// One access in flight; raw load word is returned for downstream slicing.
module lsu_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rsp_rdata_o,
   output logic [1:0]  rsp_dsel_o,
   output logic [2:0]  rsp_funct3_o
);

   lsu_state_t  state_r, state_nxt_s;
   logic [7:0]  cnt_r;
   logic        we_r, err_r;
   logic [31:0] addr_r, wdata_r, rdata_r;
   logic [3:0]  be_r;
   logic [1:0]  dsel_r;
   logic [2:0]  funct3_r;

   logic [3:0]  be_s;
   logic [31:0] wdata_rep_s;
   logic        misaligned_s, hs_s, bad_s, timeout_s;

   lsu_store_align u_align (
      .size       (req_funct3_i[1:0]),
      .off        (req_addr_i[1:0]),
      .wdata      (req_wdata_i),
      .be         (be_s),
      .wdata_rep  (wdata_rep_s),
      .misaligned (misaligned_s)
   );

   assign hs_s      = req_valid_i & (state_r == LSU_IDLE);
   assign bad_s     = ~funct3_legal(req_funct3_i, req_we_i) | misaligned_s;
   // Fires on the last permitted WAIT cycle so WAIT lasts exactly TIMEOUT_CYC cycles.
   assign timeout_s = (cnt_r == 8'(TIMEOUT_CYC - 32'd1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= LSU_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         LSU_IDLE: begin
            if (hs_s) state_nxt_s = bad_s ? LSU_RESP : LSU_REQ;
            else      state_nxt_s = LSU_IDLE;
         end
         LSU_REQ: begin
            if (mem_gnt_i) state_nxt_s = we_r ? LSU_RESP : LSU_WAIT;
            else           state_nxt_s = LSU_REQ;
         end
         LSU_WAIT: begin
            if (mem_rvalid_i || timeout_s) state_nxt_s = LSU_RESP;
            else                           state_nxt_s = LSU_WAIT;
         end
         LSU_RESP: state_nxt_s = LSU_IDLE;
         default:  state_nxt_s = LSU_IDLE;
      endcase
   end

   // WAIT-cycle counter, held at zero in every other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    cnt_r <= 8'd0;
      else if (state_r == LSU_WAIT)  cnt_r <= cnt_r + 8'd1;
      else                           cnt_r <= 8'd0;
   end

   // Access latch at handshake and response capture in WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r     <= 1'b0;
         addr_r   <= 32'h0000_0000;
         be_r     <= 4'b0000;
         wdata_r  <= 32'h0000_0000;
         dsel_r   <= 2'b00;
         funct3_r <= 3'b000;
         err_r    <= 1'b0;
         rdata_r  <= 32'h0000_0000;
      end else if (hs_s) begin
         we_r     <= req_we_i;
         addr_r   <= {req_addr_i[31:2], 2'b00};
         be_r     <= req_we_i ? be_s : 4'b1111;
         wdata_r  <= req_we_i ? wdata_rep_s : 32'h0000_0000;
         dsel_r   <= req_addr_i[1:0];
         funct3_r <= req_funct3_i;
         err_r    <= bad_s;
         rdata_r  <= 32'h0000_0000;
      end else if (state_r == LSU_WAIT) begin
         if (mem_rvalid_i) begin
            rdata_r <= mem_rdata_i;
            err_r   <= 1'b0;
         end else if (timeout_s) begin
            err_r   <= 1'b1;
         end
      end
   end

   assign req_ready_o  = (state_r == LSU_IDLE);
   assign mem_req_o    = (state_r == LSU_REQ);
   assign rsp_valid_o  = (state_r == LSU_RESP);
   assign mem_we_o     = we_r;
   assign mem_addr_o   = addr_r;
   assign mem_be_o     = be_r;
   assign mem_wdata_o  = wdata_r;
   assign rsp_err_o    = err_r;
   assign rsp_rdata_o  = rdata_r;
   assign rsp_dsel_o   = dsel_r;
   assign rsp_funct3_o = funct3_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: default-timeout instance plus a TIMEOUT_CYC=4
// instance sharing the same stimulus.
module tb_lsu_ctrl;

   logic        clk_s = 1'b0;
   logic        rst_n_s;
   logic        req_valid_s, req_we_s;
   logic [2:0]  req_funct3_s;
   logic [31:0] req_addr_s, req_wdata_s;
   logic        mem_gnt_s, mem_rvalid_s;
   logic [31:0] mem_rdata_s;

   logic        req_ready_s, mem_req_s, mem_we_s, rsp_valid_s, rsp_err_s;
   logic [31:0] mem_addr_s, mem_wdata_s, rsp_rdata_s;
   logic [3:0]  mem_be_s;
   logic [1:0]  rsp_dsel_s;
   logic [2:0]  rsp_funct3_s;

   logic        req_ready4_s, mem_req4_s, mem_we4_s, rsp_valid4_s, rsp_err4_s;
   logic [31:0] mem_addr4_s, mem_wdata4_s, rsp_rdata4_s;
   logic [3:0]  mem_be4_s;
   logic [1:0]  rsp_dsel4_s;
   logic [2:0]  rsp_funct34_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_s = ~clk_s;

   lsu_ctrl dut (
      .clk(clk_s), .rst_n(rst_n_s),
      .req_valid_i(req_valid_s), .req_ready_o(req_ready_s), .req_we_i(req_we_s),
      .req_funct3_i(req_funct3_s), .req_addr_i(req_addr_s), .req_wdata_i(req_wdata_s),
      .mem_req_o(mem_req_s), .mem_we_o(mem_we_s), .mem_addr_o(mem_addr_s),
      .mem_be_o(mem_be_s), .mem_wdata_o(mem_wdata_s), .mem_gnt_i(mem_gnt_s),
      .mem_rvalid_i(mem_rvalid_s), .mem_rdata_i(mem_rdata_s),
      .rsp_valid_o(rsp_valid_s), .rsp_err_o(rsp_err_s), .rsp_rdata_o(rsp_rdata_s),
      .rsp_dsel_o(rsp_dsel_s), .rsp_funct3_o(rsp_funct3_s)
   );

   lsu_ctrl #(.TIMEOUT_CYC(4)) dut4 (
      .clk(clk_s), .rst_n(rst_n_s),
      .req_valid_i(req_valid_s), .req_ready_o(req_ready4_s), .req_we_i(req_we_s),
      .req_funct3_i(req_funct3_s), .req_addr_i(req_addr_s), .req_wdata_i(req_wdata_s),
      .mem_req_o(mem_req4_s), .mem_we_o(mem_we4_s), .mem_addr_o(mem_addr4_s),
      .mem_be_o(mem_be4_s), .mem_wdata_o(mem_wdata4_s), .mem_gnt_i(mem_gnt_s),
      .mem_rvalid_i(mem_rvalid_s), .mem_rdata_i(mem_rdata_s),
      .rsp_valid_o(rsp_valid4_s), .rsp_err_o(rsp_err4_s), .rsp_rdata_o(rsp_rdata4_s),
      .rsp_dsel_o(rsp_dsel4_s), .rsp_funct3_o(rsp_funct34_s)
   );

   task automatic apply_reset();
      rst_n_s = 1'b0;
      req_valid_s = 1'b0; mem_gnt_s = 1'b0; mem_rvalid_s = 1'b0;
      @(negedge clk_s);
      rst_n_s = 1'b1;
      @(negedge clk_s);
   endtask

   task automatic test_reset();
      rst_n_s = 1'b0;
      req_valid_s = 1'b0; req_we_s = 1'b0; req_funct3_s = 3'b000;
      req_addr_s = 32'h0; req_wdata_s = 32'h0;
      mem_gnt_s = 1'b0; mem_rvalid_s = 1'b0; mem_rdata_s = 32'h0;
      repeat (2) @(negedge clk_s);
      n_checks++; if (req_ready_s !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", req_ready_s); end
      n_checks++; if (mem_req_s !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %0b want 0", mem_req_s); end
      n_checks++; if (rsp_valid_s !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid_s); end
      n_checks++; if (mem_be_s !== 4'b0000) begin n_fail++; $display("FAIL rst_be: got %b want 0000", mem_be_s); end
      n_checks++; if (mem_addr_s !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr_s); end
      n_checks++; if (rsp_rdata_s !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata_s); end
      rst_n_s = 1'b1;
      @(negedge clk_s);
      n_checks++; if (req_ready_s !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %0b want 1", req_ready_s); end
   endtask

   task automatic test_load_word();
      req_valid_s = 1'b1; req_we_s = 1'b0; req_funct3_s = 3'b010; req_addr_s = 32'h0000_0100;
      @(negedge clk_s);
      n_checks++; if (mem_req_s !== 1'b1) begin n_fail++; $display("FAIL lw_mem_req: got %0b want 1", mem_req_s); end
      n_checks++; if (mem_addr_s !== 32'h0000_0100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", mem_addr_s); end
      n_checks++; if (mem_be_s !== 4'b1111) begin n_fail++; $display("FAIL lw_be: got %b want 1111", mem_be_s); end
      n_checks++; if (mem_we_s !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %0b want 0", mem_we_s); end
      n_checks++; if (mem_wdata_s !== 32'h0) begin n_fail++; $display("FAIL lw_wdata: got %h want 0", mem_wdata_s); end
      req_valid_s = 1'b0; mem_gnt_s = 1'b1;
      @(negedge clk_s);
      n_checks++; if (mem_req_s !== 1'b0) begin n_fail++; $display("FAIL lw_req_drop: got %0b want 0", mem_req_s); end
      mem_gnt_s = 1'b0; mem_rvalid_s = 1'b1; mem_rdata_s = 32'hDEAD_BEEF;
      @(negedge clk_s);
      mem_rvalid_s = 1'b0;
      n_checks++; if (rsp_valid_s !== 1'b1) begin n_fail++; $display("FAIL lw_rsp_valid: got %0b want 1", rsp_valid_s); end
      n_checks++; if (rsp_rdata_s !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", rsp_rdata_s); end
      n_checks++; if (rsp_dsel_s !== 2'b00) begin n_fail++; $display("FAIL lw_dsel: got %b want 00", rsp_dsel_s); end
      n_checks++; if (rsp_err_s !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %0b want 0", rsp_err_s); end
      n_checks++; if (rsp_funct3_s !== 3'b010) begin n_fail++; $display("FAIL lw_funct3: got %b want 010", rsp_funct3_s); end
      @(negedge clk_s);
      n_checks++; if (rsp_valid_s !== 1'b0) begin n_fail++; $display("FAIL lw_rsp_pulse: got %0b want 0", rsp_valid_s); end
      n_checks++; if (req_ready_s !== 1'b1) begin n_fail++; $display("FAIL lw_ready_back: got %0b want 1", req_ready_s); end
   endtask

   task automatic test_store_byte_delayed_gnt();
      req_valid_s = 1'b1; req_we_s = 1'b1; req_funct3_s = 3'b000;
      req_addr_s = 32'h0000_0203; req_wdata_s = 32'h0000_00A5;
      @(negedge clk_s);
      req_valid_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (mem_req_s !== 1'b1) begin n_fail++; $display("FAIL sb_req_held%0d: got %0b want 1", i, mem_req_s); end
         if (i == 3) mem_gnt_s = 1'b1;
         @(negedge clk_s);
      end
      mem_gnt_s = 1'b0;
      n_checks++; if (rsp_valid_s !== 1'b1) begin n_fail++; $display("FAIL sb_rsp_valid: got %0b want 1", rsp_valid_s); end
      n_checks++; if (mem_be_s !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", mem_be_s); end
      n_checks++; if (mem_wdata_s !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata_s); end
      n_checks++; if (mem_addr_s !== 32'h0000_0200) begin n_fail++; $display("FAIL sb_addr: got %h want 00000200", mem_addr_s); end
      n_checks++; if (rsp_err_s !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %0b want 0", rsp_err_s); end
      n_checks++; if (rsp_rdata_s !== 32'h0) begin n_fail++; $display("FAIL sb_rdata: got %h want 0", rsp_rdata_s); end
      @(negedge clk_s);
   endtask

   task automatic test_misaligned_and_half_store();
      req_valid_s = 1'b1; req_we_s = 1'b0; req_funct3_s = 3'b001; req_addr_s = 32'h0000_0101;
      @(negedge clk_s);
      req_valid_s = 1'b0;
      n_checks++; if (mem_req_s !== 1'b0) begin n_fail++; $display("FAIL lh_mis_no_req: got %0b want 0", mem_req_s); end
      n_checks++; if (rsp_valid_s !== 1'b1) begin n_fail++; $display("FAIL lh_mis_rsp: got %0b want 1", rsp_valid_s); end
      n_checks++; if (rsp_err_s !== 1'b1) begin n_fail++; $display("FAIL lh_mis_err: got %0b want 1", rsp_err_s); end
      @(negedge clk_s);
      req_valid_s = 1'b1; req_we_s = 1'b1; req_funct3_s = 3'b100; req_addr_s = 32'h0000_0100;
      @(negedge clk_s);
      req_valid_s = 1'b0;
      n_checks++; if (mem_req_s !== 1'b0) begin n_fail++; $display("FAIL sbu_no_req: got %0b want 0", mem_req_s); end
      n_checks++; if (rsp_err_s !== 1'b1) begin n_fail++; $display("FAIL sbu_err: got %0b want 1", rsp_err_s); end
      @(negedge clk_s);
      req_valid_s = 1'b1; req_we_s = 1'b1; req_funct3_s = 3'b001;
      req_addr_s = 32'h0000_0102; req_wdata_s = 32'h0000_1234;
      @(negedge clk_s);
      req_valid_s = 1'b0;
      n_checks++; if (mem_req_s !== 1'b1) begin n_fail++; $display("FAIL sh_req: got %0b want 1", mem_req_s); end
      n_checks++; if (mem_be_s !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", mem_be_s); end
      n_checks++; if (mem_wdata_s !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_wdata: got %h want 12341234", mem_wdata_s); end
      n_checks++; if (mem_we_s !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %0b want 1", mem_we_s); end
      mem_gnt_s = 1'b1;
      @(negedge clk_s);
      mem_gnt_s = 1'b0;
      n_checks++; if (rsp_valid_s !== 1'b1 || rsp_err_s !== 1'b0) begin n_fail++; $display("FAIL sh_rsp: got valid %0b err %0b want 1 0", rsp_valid_s, rsp_err_s); end
      @(negedge clk_s);
   endtask

   task automatic test_timeout();
      for (int pass = 0; pass < 2; pass++) begin
         req_valid_s = 1'b1; req_we_s = 1'b0; req_funct3_s = 3'b000; req_addr_s = 32'h0000_0042;
         @(negedge clk_s);
         req_valid_s = 1'b0;
         n_checks++; if (mem_req4_s !== 1'b1) begin n_fail++; $display("FAIL to%0d_req: got %0b want 1", pass, mem_req4_s); end
         mem_gnt_s = 1'b1;
         @(negedge clk_s);
         mem_gnt_s = 1'b0;
         for (int w = 0; w < 4; w++) begin
            n_checks++; if (rsp_valid4_s !== 1'b0) begin n_fail++; $display("FAIL to%0d_wait%0d: got %0b want 0", pass, w, rsp_valid4_s); end
            if (pass == 1 && w == 3) begin mem_rvalid_s = 1'b1; mem_rdata_s = 32'h1122_3344; end
            @(negedge clk_s);
         end
         mem_rvalid_s = 1'b0;
         n_checks++; if (rsp_valid4_s !== 1'b1) begin n_fail++; $display("FAIL to%0d_rsp: got %0b want 1", pass, rsp_valid4_s); end
         n_checks++; if (rsp_err4_s !== (pass == 0)) begin n_fail++; $display("FAIL to%0d_err: got %0b want %0b", pass, rsp_err4_s, pass == 0); end
         n_checks++; if (rsp_rdata4_s !== ((pass == 0) ? 32'h0 : 32'h1122_3344)) begin n_fail++; $display("FAIL to%0d_rdata: got %h", pass, rsp_rdata4_s); end
         n_checks++; if (rsp_dsel4_s !== 2'b10) begin n_fail++; $display("FAIL to%0d_dsel: got %b want 10", pass, rsp_dsel4_s); end
         @(negedge clk_s);
         n_checks++; if (rsp_valid4_s !== 1'b0) begin n_fail++; $display("FAIL to%0d_pulse: got %0b want 0", pass, rsp_valid4_s); end
         apply_reset();
      end
   endtask

   task automatic test_reset_mid_req();
      req_valid_s = 1'b1; req_we_s = 1'b0; req_funct3_s = 3'b010; req_addr_s = 32'h0000_0300;
      @(negedge clk_s);
      req_valid_s = 1'b0;
      n_checks++; if (mem_req_s !== 1'b1) begin n_fail++; $display("FAIL rmid_req_before: got %0b want 1", mem_req_s); end
      #2 rst_n_s = 1'b0;
      #1;
      n_checks++; if (mem_req_s !== 1'b0) begin n_fail++; $display("FAIL rmid_req_drop: got %0b want 0", mem_req_s); end
      n_checks++; if (req_ready_s !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0b want 1", req_ready_s); end
      @(negedge clk_s);
      rst_n_s = 1'b1;
      mem_rvalid_s = 1'b1; mem_rdata_s = 32'hCAFE_F00D;
      @(negedge clk_s);
      mem_rvalid_s = 1'b0;
      n_checks++; if (rsp_valid_s !== 1'b0) begin n_fail++; $display("FAIL rmid_late_rvalid: got %0b want 0", rsp_valid_s); end
      @(negedge clk_s);
      n_checks++; if (rsp_valid_s !== 1'b0 || req_ready_s !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got valid %0b ready %0b want 0 1", rsp_valid_s, req_ready_s); end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      logic [1:0] exp_dsel;
      req_valid_s = 1'b1; req_we_s = 1'b0; req_funct3_s = 3'b100;
      for (int i = 0; i < 4; i++) begin
         exp_dsel = 2'd3 - 2'(i);
         n_checks++; if (req_ready_s !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %0b want 1", i, req_ready_s); end
         req_addr_s = {30'd0, exp_dsel};
         @(negedge clk_s);
         if (rsp_valid_s === 1'b1) pulses++;
         mem_gnt_s = 1'b1;
         @(negedge clk_s);
         if (rsp_valid_s === 1'b1) pulses++;
         mem_gnt_s = 1'b0; mem_rvalid_s = 1'b1; mem_rdata_s = 32'h0000_0100 + 32'(i);
         @(negedge clk_s);
         mem_rvalid_s = 1'b0;
         if (rsp_valid_s === 1'b1) pulses++;
         n_checks++; if (rsp_dsel_s !== exp_dsel) begin n_fail++; $display("FAIL b2b_dsel%0d: got %b want %b", i, rsp_dsel_s, exp_dsel); end
         n_checks++; if (rsp_rdata_s !== 32'h0000_0100 + 32'(i)) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h", i, rsp_rdata_s); end
         n_checks++; if (rsp_funct3_s !== 3'b100) begin n_fail++; $display("FAIL b2b_funct3%0d: got %b want 100", i, rsp_funct3_s); end
         @(negedge clk_s);
         if (rsp_valid_s === 1'b1) pulses++;
      end
      req_valid_s = 1'b0;
      @(negedge clk_s);
      if (rsp_valid_s === 1'b1) pulses++;
      n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_store_byte_delayed_gnt();
      test_misaligned_and_half_store();
      test_timeout();
      test_reset_mid_req();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
